// File: rtl/arb_pkg.sv
// Shared definitions for the request issuer: line count, service FSM encoding,
// default service slice length and small one-hot helpers.
package arb_pkg;

    localparam int NUM_LINES            = 4;
    localparam int LINE_W               = 2;
    localparam int DEFAULT_SLICE_CYCLES = 150_000_000;

    typedef logic [LINE_W-1:0]    line_t;
    typedef logic [NUM_LINES-1:0] line_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_one_hot(input line_mask_t m);
        return (m != '0) && ((m & (m - line_mask_t'(1))) == '0);
    endfunction

    function automatic line_t mask_to_line(input line_mask_t m);
        line_t idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (m[i]) idx = line_t'(i);
        end
        return idx;
    endfunction

    function automatic line_mask_t line_to_mask(input line_t l);
        return line_mask_t'(1) << l;
    endfunction

endpackage

// File: rtl/request_issuer_if.sv
// Job/arbiter/status bundle of the request issuer; the issuer is the slave,
// the surrounding system (arbiter, job sources, status readout) the master.
interface request_issuer_if #(
    parameter int DEPTH_W = 3
);
    import arb_pkg::*;

    line_mask_t         job_push;
    line_mask_t         grant_in;
    line_mask_t         request_queue;
    line_mask_t         service_led;
    line_mask_t         job_done;
    line_mask_t         overflow;
    line_t              pend_sel;
    logic [DEPTH_W-1:0] pend_count;

    modport master (
        output job_push, grant_in, pend_sel,
        input  request_queue, service_led, job_done, overflow, pend_count
    );

    modport slave (
        input  job_push, grant_in, pend_sel,
        output request_queue, service_led, job_done, overflow, pend_count
    );

endinterface

// File: rtl/request_issuer_pending_counter.sv
// Saturating per-line pending-job counter with a sticky overflow flag that
// records any push attempted while the counter is full.
module pending_counter #(
    parameter int DEPTH_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] count,
    output logic               overflow
);

    localparam logic [DEPTH_W-1:0] COUNT_MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == COUNT_MAX) overflow <= 1'b1;
            else                    count    <= count + DEPTH_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/request_issuer.sv
// Request issuer: per-line pending job counters feeding an arbiter, plus a
// service FSM that holds a granted line for one time slice and retires a job.
module request_issuer
    import arb_pkg::*;
#(
    parameter int SLICE_CYCLES = DEFAULT_SLICE_CYCLES,
    parameter int DEPTH_W      = 3
) (
    input  logic            clk,
    input  logic            reset,
    request_issuer_if.slave bus
);

    localparam int                 SLICE_W    = $clog2(SLICE_CYCLES);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);

    state_t             state, state_nxt;
    line_t              line_q, line_nxt;
    logic [SLICE_W-1:0] slice_q, slice_nxt;

    logic [DEPTH_W-1:0] count [NUM_LINES];
    line_mask_t         ovf;
    line_mask_t         pending;
    line_mask_t         done_mask;
    line_t              grant_line;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        pending_counter #(.DEPTH_W(DEPTH_W)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (bus.job_push[i]),
            .dec      (done_mask[i]),
            .count    (count[i]),
            .overflow (ovf[i])
        );
        assign pending[i] = (count[i] != '0);
    end

    assign grant_line = mask_to_line(bus.grant_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            line_q  <= '0;
            slice_q <= '0;
        end else begin
            state   <= state_nxt;
            line_q  <= line_nxt;
            slice_q <= slice_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        line_nxt  = line_q;
        slice_nxt = slice_q;
        case (state)
            ST_IDLE: begin
                if (is_one_hot(bus.grant_in) && pending[grant_line]) begin
                    state_nxt = ST_SERVE;
                    line_nxt  = grant_line;
                    slice_nxt = '0;
                end
            end
            ST_SERVE: begin
                // Losing the grant aborts the slice; the job stays pending.
                if (!bus.grant_in[line_q])   state_nxt = ST_IDLE;
                else if (slice_q == SLICE_LAST) state_nxt = ST_DONE;
                else                         slice_nxt = slice_q + SLICE_W'(1);
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign done_mask = (state == ST_DONE) ? line_to_mask(line_q) : '0;

    assign bus.request_queue = pending;
    assign bus.job_done      = done_mask;
    assign bus.overflow      = ovf;
    assign bus.service_led   = (state == ST_SERVE || state == ST_DONE)
                             ? line_to_mask(line_q) : '0;
    assign bus.pend_count    = count[bus.pend_sel];

endmodule

// File: tb/tb_request_issuer.sv
// Directed bench for request_issuer (SLICE_CYCLES=4, DEPTH_W=3): a vector
// table for per-cycle behaviour plus hand-written multi-cycle sequences.
module tb_request_issuer;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic reset;

    request_issuer_if #(.DEPTH_W(3)) bus ();

    request_issuer #(
        .SLICE_CYCLES (4),
        .DEPTH_W      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] push;
        logic [3:0] grant;
        logic [1:0] sel;
        logic [3:0] rq;
        logic [3:0] led;
        logic [3:0] done;
        logic [3:0] ovf;
        logic [2:0] pend;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] rq, input logic [3:0] led,
                              input logic [3:0] done, input logic [3:0] ovf, input logic [2:0] pend);
        check({tag, ".request_queue"}, 32'(bus.request_queue), 32'(rq));
        check({tag, ".service_led"},   32'(bus.service_led),   32'(led));
        check({tag, ".job_done"},      32'(bus.job_done),      32'(done));
        check({tag, ".overflow"},      32'(bus.overflow),      32'(ovf));
        check({tag, ".pend_count"},    32'(bus.pend_count),    32'(pend));
    endtask

    task automatic add(input logic [3:0] push, input logic [3:0] grant, input logic [1:0] sel,
                       input logic [3:0] rq, input logic [3:0] led, input logic [3:0] done,
                       input logic [3:0] ovf, input logic [2:0] pend);
        vec_t v;
        v.push = push; v.grant = grant; v.sel = sel;
        v.rq = rq; v.led = led; v.done = done; v.ovf = ovf; v.pend = pend;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Single job on line 2, served with a continuously held grant.
        add(4'b0100, 4'b0000, 2'd2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 3'd1);
        add(4'b0000, 4'b0100, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add(4'b0000, 4'b0000, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        // Eight pushes on line 0: saturate at 7, eighth sets overflow.
        for (int k = 1; k <= 8; k++)
            add(4'b0001, 4'b0000, 2'd0, 4'b0001, 4'b0000, 4'b0000,
                (k == 8) ? 4'b0001 : 4'b0000, (k > 7) ? 3'd7 : 3'(k));
        // Multi-hot, zero and non-pending grants are ignored in IDLE.
        add(4'b0010, 4'b0011, 2'd0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 3'd7);
        add(4'b0000, 4'b0011, 2'd1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 3'd1);
        add(4'b0000, 4'b0000, 2'd0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 3'd7);
        add(4'b0000, 4'b1000, 2'd0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 3'd7);

        bus.job_push = '0;
        bus.grant_in = '0;
        bus.pend_sel = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0, 4'b0, 4'b0, 4'b0, 3'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.job_push = vecs[i].push;
            bus.grant_in = vecs[i].grant;
            bus.pend_sel = vecs[i].sel;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].rq, vecs[i].led,
                       vecs[i].done, vecs[i].ovf, vecs[i].pend);
        end

        // Reset mid-SERVE on line 0 (count 7, overflow set): everything clears at once.
        bus.job_push = '0;
        bus.grant_in = 4'b0001;
        bus.pend_sel = 2'd0;
        step();
        check("rst_mid.led_serve1", 32'(bus.service_led), 32'h1);
        step();
        check("rst_mid.led_serve2", 32'(bus.service_led), 32'h1);
        reset = 1'b1;
        #1;
        check_outs("rst_mid.async", 4'b0, 4'b0, 4'b0, 4'b0, 3'd0);
        step();
        check_outs("rst_mid.held", 4'b0, 4'b0, 4'b0, 4'b0, 3'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_outs($sformatf("rst_mid.after%0d", k), 4'b0, 4'b0, 4'b0, 4'b0, 3'd0);
        end

        // Grant on line 1 dropped after two SERVE cycles: abort, job stays pending.
        bus.grant_in = '0;
        do_reset();
        bus.job_push = 4'b0010;
        bus.pend_sel = 2'd1;
        step();
        bus.job_push = '0;
        bus.grant_in = 4'b0010;
        step();
        check("abort.led_serve1", 32'(bus.service_led), 32'h2);
        step();
        check("abort.led_serve2", 32'(bus.service_led), 32'h2);
        bus.grant_in = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_outs($sformatf("abort.idle%0d", k), 4'b0010, 4'b0, 4'b0, 4'b0, 3'd1);
        end

        // Line 3 with two jobs; a push landing in the DONE cycle cancels the decrement.
        do_reset();
        bus.job_push = 4'b1000;
        bus.pend_sel = 2'd3;
        step();
        step();
        bus.job_push = '0;
        check("done_push.pend_init", 32'(bus.pend_count), 32'd2);
        bus.grant_in = 4'b1000;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.job_done == '0 && n < 20);
        check("done_push.latency", 32'(n), 32'd5);
        check_outs("done_push.done", 4'b1000, 4'b1000, 4'b1000, 4'b0, 3'd2);
        bus.job_push = 4'b1000;
        bus.grant_in = '0;
        step();
        bus.job_push = '0;
        check_outs("done_push.after", 4'b1000, 4'b0, 4'b0, 4'b0, 3'd2);
        step();
        check_outs("done_push.settle", 4'b1000, 4'b0, 4'b0, 4'b0, 3'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/request_issuer.md
REQUEST_ISSUER -- requirements
Module: request_issuer

Interface
REQ-001 SHALL have parameter SLICE_CYCLES, default 150000000, meaning service time per granted job in clk cycles (3 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEPTH_W, default 3, meaning pending-job counter width per line (max 2^DEPTH_W-1 jobs).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port job_push  input  4  per-line one-cycle pulse adding one pending job.
REQ-006 SHALL have port grant_in  input  4  one-hot grant from the round-robin arbiter.
REQ-007 SHALL have port request_queue  output  4  per-line request to the arbiter.
REQ-008 SHALL have port service_led  output  4  one-hot line currently being serviced, else 0.
REQ-009 SHALL have port job_done  output  4  one-cycle pulse on the line whose job completed.
REQ-010 SHALL have port overflow  output  4  sticky per-line flag: push attempted at full.
REQ-011 SHALL have port pend_sel  input  2  line select for count readout.
REQ-012 SHALL have port pend_count  output  DEPTH_W  pending count of line pend_sel, combinational.

Function
REQ-013 Per line i, count[i] SHALL increment on job_push[i], decrement on completion of line i, and stay unchanged when both occur in the same cycle.
REQ-014 Push with count[i] at max and no same-cycle completion SHALL leave count[i] unchanged and set overflow[i] until reset.
REQ-015 Decrement SHALL never occur at count 0; no wrap-around in either direction.
REQ-016 request_queue[i] SHALL equal (count[i] != 0), derived from registered count.
REQ-017 Service FSM SHALL have states IDLE, SERVE, DONE.
REQ-018 IDLE -> SERVE when grant_in is exactly one-hot and the granted line has count > 0; latch line index, clear slice counter; otherwise stay IDLE.
REQ-019 grant_in that is zero or multi-hot SHALL be ignored in IDLE.
REQ-020 SERVE: slice counter increments each cycle; when it reaches SLICE_CYCLES-1 with grant still held -> DONE.
REQ-021 SERVE: if grant_in bit of latched line is 0 in any cycle -> IDLE (abort), no decrement, no job_done.
REQ-022 DONE lasts exactly one cycle: job_done[latched]=1, count[latched] decrements, -> IDLE.
REQ-023 Latency: grant sampled in IDLE at cycle t, held continuously -> job_done high in cycle t+SLICE_CYCLES+1.
REQ-024 service_led SHALL be one-hot of latched line in SERVE and DONE, 0 in IDLE.
REQ-025 Pushes to any line, including the line in service, SHALL be accepted in every state.

Reset
REQ-026 Asserting reset SHALL immediately force: all counts 0, overflow 0, FSM IDLE, slice counter 0, latched line 0.
REQ-027 During and after reset: request_queue=0, service_led=0, job_done=0, overflow=0, pend_count=0.
REQ-028 Reset mid-SERVE SHALL discard the in-flight job without job_done pulse.

Structure
REQ-029 Shared package arb_pkg SHALL hold NUM_LINES=4, the FSM state encoding, and default SLICE_CYCLES.
REQ-030 One sub-module pending_counter (saturating up/down counter with overflow flag) SHALL be instantiated once per line.

Verification (SLICE_CYCLES=4, DEPTH_W=3)
REQ-031 Push line 2 once, then grant_in=0100 held -> request_queue=0100, SERVE next cycle, job_done=0100 in cycle t+5, request_queue=0000 after.
REQ-032 Push line 0 eight times, no grant -> count saturates at 7, overflow=0001, pend_sel=0 gives pend_count=7.
REQ-033 Line 1 count 1, grant 0010 dropped after 2 SERVE cycles -> IDLE, no job_done, count stays 1, request_queue[1]=1.
REQ-034 Line 3 count 2, push line 3 in the DONE cycle -> count stays 2, job_done=1000.
REQ-035 grant_in=0011 with lines 0,1 pending -> stays IDLE, service_led=0000.
REQ-036 Reset asserted during SERVE -> all outputs 0 immediately, no job_done, counts 0.
